// File: rtl/el_timing_gen_if.sv
// rtl/el_timing_gen_if.sv - run control and timing outputs of the EL timing generator
//
// Purpose : groups the enable input and the registered timing outputs of
//           el_timing_gen so the generator and its consumer share one bundle.
// Signals : enable    - run timing when high (consumer -> generator)
//           HS        - horizontal sync, active high
//           VS        - vertical sync, active high
//           pixValid  - current cycle carries an active pixel word
//           pixCount  - word index within the active line
//           lineCount - active line index
//           field     - odd/even frame indicator
// Modports: master = timing generator, slave = consumer of the timing.
interface el_timing_gen_if;
   logic       enable;
   logic       HS;
   logic       VS;
   logic       pixValid;
   logic [7:0] pixCount;
   logic [7:0] lineCount;
   logic       field;

   modport master (
      input  enable,
      output HS, VS, pixValid, pixCount, lineCount, field
   );

   modport slave (
      output enable,
      input  HS, VS, pixValid, pixCount, lineCount, field
   );
endinterface

// File: rtl/el_timing_gen.sv
// rtl/el_timing_gen.sv - raster timing generator for an EL panel (4-pixel words)
//
// Purpose : free-running horizontal/vertical counters producing registered
//           sync, active-video and position outputs. Every output is decoded
//           from the counter values present before the clock edge, so each
//           output update describes the (h,v) of one counter cycle.
// Ports   : Vclk   - pixel-word clock, all logic on the rising edge
//           nReset - asynchronous active-low reset
//           tg     - el_timing_gen_if.master (enable in; HS, VS, pixValid,
//                    pixCount, lineCount, field out)
// Options : EL_TIMING_FIELD_EN - when defined, field toggles on every frame
//           wrap; otherwise field is tied to 0 and no field register exists.
module el_timing_gen #(
   parameter int H_ACTIVE = 80,
   parameter int H_FP     = 4,
   parameter int H_SYNC   = 8,
   parameter int H_BP     = 4,
   parameter int V_ACTIVE = 240,
   parameter int V_FP     = 2,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 2
) (
   input  logic               Vclk,
   input  logic               nReset,
   el_timing_gen_if.master    tg
);

   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // One extra count of headroom keeps the counters wide enough to also
   // hold H_ACTIVE/V_ACTIVE themselves for the range comparisons.
   localparam int HW = $clog2(HT + 1);
   localparam int VW = $clog2(VT + 1);

   localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
   localparam logic [VW-1:0] V_LAST = VW'(VT - 1);

   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          h_wrap;
   logic          v_wrap;

   logic          hs_d;
   logic          vs_d;
   logic          pix_d;
   logic [7:0]    pixcnt_d;
   logic [7:0]    linecnt_d;

   logic          hs_q;
   logic          vs_q;
   logic          pix_q;
   logic [7:0]    pixcnt_q;
   logic [7:0]    linecnt_q;

   assign h_wrap = (h == H_LAST);
   assign v_wrap = (v == V_LAST);

   // Decode of the current counter values; registered below.
   always_comb begin
      pix_d     = 1'b0;
      hs_d      = 1'b0;
      vs_d      = 1'b0;
      pixcnt_d  = 8'd0;
      linecnt_d = 8'd0;
      pix_d     = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
      // HS runs on blanking lines too, so it ignores v entirely.
      hs_d      = (int'(h) >= HS_START) && (int'(h) < HS_END);
      // VS depends on v only, so it rises and falls with the line at h=0.
      vs_d      = (int'(v) >= VS_START) && (int'(v) < VS_END);
      if (pix_d) begin
         pixcnt_d  = 8'(h);
         linecnt_d = 8'(v);
      end
   end

   always_ff @(posedge Vclk or negedge nReset) begin
      if (!nReset) begin
         h         <= '0;
         v         <= '0;
         hs_q      <= 1'b0;
         vs_q      <= 1'b0;
         pix_q     <= 1'b0;
         pixcnt_q  <= 8'd0;
         linecnt_q <= 8'd0;
      end else if (!tg.enable) begin
         // Parked at the frame origin so re-enabling starts a clean frame.
         h         <= '0;
         v         <= '0;
         hs_q      <= 1'b0;
         vs_q      <= 1'b0;
         pix_q     <= 1'b0;
         pixcnt_q  <= 8'd0;
         linecnt_q <= 8'd0;
      end else begin
         h         <= h_wrap ? '0 : h + HW'(1);
         if (h_wrap) begin
            v <= v_wrap ? '0 : v + VW'(1);
         end
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         pix_q     <= pix_d;
         pixcnt_q  <= pixcnt_d;
         linecnt_q <= linecnt_d;
      end
   end

   assign tg.HS        = hs_q;
   assign tg.VS        = vs_q;
   assign tg.pixValid  = pix_q;
   assign tg.pixCount  = pixcnt_q;
   assign tg.lineCount = linecnt_q;

`ifdef EL_TIMING_FIELD_EN
   logic field_q;

   // Toggles on the edge where both counters wrap; holds while disabled.
   always_ff @(posedge Vclk or negedge nReset) begin
      if (!nReset) begin
         field_q <= 1'b0;
      end else if (tg.enable && h_wrap && v_wrap) begin
         field_q <= ~field_q;
      end
   end

   assign tg.field = field_q;
`else
   assign tg.field = 1'b0;
`endif

endmodule

// File: tb/tb_el_timing_gen.sv
// tb/tb_el_timing_gen.sv - directed self-checking bench for el_timing_gen
module tb_el_timing_gen;

`ifdef EL_TIMING_FIELD_EN
   localparam bit FIELD_EN = 1'b1;
`else
   localparam bit FIELD_EN = 1'b0;
`endif

   localparam int D_FRAME = 96 * 246;   // 23616
   localparam int S_FRAME = 7 * 5;      // 35

   logic Vclk;
   logic nReset;
   int   errors;
   int   checks;

   el_timing_gen_if bus ();
   el_timing_gen_if bus_s ();

   el_timing_gen u_dut (
      .Vclk   (Vclk),
      .nReset (nReset),
      .tg     (bus)
   );

   el_timing_gen #(
      .H_ACTIVE (4),
      .H_FP     (1),
      .H_SYNC   (1),
      .H_BP     (1),
      .V_ACTIVE (2),
      .V_FP     (1),
      .V_SYNC   (1),
      .V_BP     (1)
   ) u_small (
      .Vclk   (Vclk),
      .nReset (nReset),
      .tg     (bus_s)
   );

   initial Vclk = 1'b0;
   always #5 Vclk = ~Vclk;

   task automatic tick;
      @(posedge Vclk);
      #1;
   endtask

   task automatic test_reset;
      nReset       = 1'b0;
      bus.enable   = 1'b0;
      bus_s.enable = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.HS !== 1'b0) begin errors++; $display("FAIL reset_HS got=%b want=0", bus.HS); end
      checks++;
      if (bus.VS !== 1'b0) begin errors++; $display("FAIL reset_VS got=%b want=0", bus.VS); end
      checks++;
      if (bus.pixValid !== 1'b0) begin errors++; $display("FAIL reset_pixValid got=%b want=0", bus.pixValid); end
      checks++;
      if (bus.pixCount !== 8'd0) begin errors++; $display("FAIL reset_pixCount got=%0d want=0", bus.pixCount); end
      checks++;
      if (bus.lineCount !== 8'd0) begin errors++; $display("FAIL reset_lineCount got=%0d want=0", bus.lineCount); end
      checks++;
      if (bus.field !== 1'b0) begin errors++; $display("FAIL reset_field got=%b want=0", bus.field); end
      checks++;
      if ({bus_s.HS, bus_s.VS, bus_s.pixValid, bus_s.field} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_small got=%b want=0000", {bus_s.HS, bus_s.VS, bus_s.pixValid, bus_s.field});
      end
   endtask

   // Runs one full default frame plus 100 cycles and checks every output
   // against the raster model, then checks the measured periods.
   task automatic test_line_frame;
      int h, v;
      logic exp_pv, exp_hs, exp_vs, exp_f;
      logic [7:0] exp_pc, exp_lc;
      int bad_pv, bad_hs, bad_vs, bad_pc, bad_lc, bad_f, first_bad;
      int pv_line0, hs_first, hs_second, lines, vs_cycles, vs_first;
      int fs_first, fs_second;
      logic hs_prev, vs_prev;
      bad_pv = 0; bad_hs = 0; bad_vs = 0; bad_pc = 0; bad_lc = 0; bad_f = 0;
      first_bad = -1;
      pv_line0 = 0; hs_first = -1; hs_second = -1; lines = 0; vs_cycles = 0;
      vs_first = -1; fs_first = -1; fs_second = -1;
      hs_prev = 1'b0; vs_prev = 1'b0;
      nReset     = 1'b1;
      bus.enable = 1'b1;
      for (int k = 0; k < D_FRAME + 100; k++) begin
         tick();
         h      = k % 96;
         v      = (k / 96) % 246;
         exp_pv = (h < 80) && (v < 240);
         exp_hs = (h >= 84) && (h <= 91);
         exp_vs = (v >= 242) && (v <= 243);
         exp_pc = exp_pv ? 8'(h) : 8'd0;
         exp_lc = exp_pv ? 8'(v) : 8'd0;
         exp_f  = FIELD_EN ? 1'(((k + 1) / D_FRAME) % 2) : 1'b0;
         if (bus.pixValid !== exp_pv) begin bad_pv++; if (first_bad < 0) first_bad = k; end
         if (bus.HS !== exp_hs) begin bad_hs++; if (first_bad < 0) first_bad = k; end
         if (bus.VS !== exp_vs) begin bad_vs++; if (first_bad < 0) first_bad = k; end
         if (bus.pixCount !== exp_pc) begin bad_pc++; if (first_bad < 0) first_bad = k; end
         if (bus.lineCount !== exp_lc) begin bad_lc++; if (first_bad < 0) first_bad = k; end
         if (bus.field !== exp_f) begin bad_f++; if (first_bad < 0) first_bad = k; end
         if (k < 96 && bus.pixValid === 1'b1) pv_line0++;
         if (bus.HS === 1'b1 && !hs_prev) begin
            if (hs_first < 0) hs_first = k;
            else if (hs_second < 0) hs_second = k;
         end
         if (k < D_FRAME && bus.pixValid === 1'b1 && bus.pixCount === 8'd0) lines++;
         if (k < D_FRAME && bus.VS === 1'b1) vs_cycles++;
         if (bus.VS === 1'b1 && !vs_prev && vs_first < 0) vs_first = k;
         if (bus.pixValid === 1'b1 && bus.pixCount === 8'd0 && bus.lineCount === 8'd0) begin
            if (fs_first < 0) fs_first = k;
            else if (fs_second < 0) fs_second = k;
         end
         hs_prev = bus.HS;
         vs_prev = bus.VS;
      end
      checks++;
      if (bad_pv !== 0) begin errors++; $display("FAIL frame_pixValid wrong_cycles=%0d want=0 first_k=%0d", bad_pv, first_bad); end
      checks++;
      if (bad_hs !== 0) begin errors++; $display("FAIL frame_HS wrong_cycles=%0d want=0 first_k=%0d", bad_hs, first_bad); end
      checks++;
      if (bad_vs !== 0) begin errors++; $display("FAIL frame_VS wrong_cycles=%0d want=0 first_k=%0d", bad_vs, first_bad); end
      checks++;
      if (bad_pc !== 0) begin errors++; $display("FAIL frame_pixCount wrong_cycles=%0d want=0 first_k=%0d", bad_pc, first_bad); end
      checks++;
      if (bad_lc !== 0) begin errors++; $display("FAIL frame_lineCount wrong_cycles=%0d want=0 first_k=%0d", bad_lc, first_bad); end
      checks++;
      if (bad_f !== 0) begin errors++; $display("FAIL frame_field wrong_cycles=%0d want=0 first_k=%0d", bad_f, first_bad); end
      checks++;
      if (pv_line0 !== 80) begin errors++; $display("FAIL line0_pixValid_cycles got=%0d want=80", pv_line0); end
      checks++;
      if (hs_first !== 84) begin errors++; $display("FAIL hs_first_rise got=%0d want=84", hs_first); end
      checks++;
      if (hs_second - hs_first !== 96) begin errors++; $display("FAIL line_period got=%0d want=96", hs_second - hs_first); end
      checks++;
      if (lines !== 240) begin errors++; $display("FAIL active_lines got=%0d want=240", lines); end
      checks++;
      if (vs_cycles !== 192) begin errors++; $display("FAIL vs_cycles got=%0d want=192", vs_cycles); end
      checks++;
      if (vs_first !== 242 * 96) begin errors++; $display("FAIL vs_first_rise got=%0d want=%0d", vs_first, 242 * 96); end
      checks++;
      if (fs_second - fs_first !== D_FRAME) begin
         errors++;
         $display("FAIL frame_period got=%0d want=%0d", fs_second - fs_first, D_FRAME);
      end
   endtask

   task automatic test_enable_low;
      bus.enable = 1'b0;
      tick();
      bus.enable = 1'b1;
      for (int k = 0; k < 9650; k++) tick();
      checks++;
      if (bus.pixCount !== 8'd49 || bus.lineCount !== 8'd100) begin
         errors++;
         $display("FAIL en_position got=%0d/%0d want=49/100", bus.pixCount, bus.lineCount);
      end
      // Internal counters now sit at h=50, v=100.
      bus.enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({bus.HS, bus.VS, bus.pixValid, bus.pixCount, bus.lineCount} !== 19'd0) begin
            errors++;
            $display("FAIL en_low_outputs cycle=%0d got=%h want=0", i,
                     {bus.HS, bus.VS, bus.pixValid, bus.pixCount, bus.lineCount});
         end
      end
      checks++;
      if (bus.field !== FIELD_EN) begin errors++; $display("FAIL en_low_field_hold got=%b want=%b", bus.field, FIELD_EN); end
      bus.enable = 1'b1;
      tick();
      checks++;
      if (bus.pixValid !== 1'b1 || bus.pixCount !== 8'd0 || bus.lineCount !== 8'd0) begin
         errors++;
         $display("FAIL en_restart got=%b/%0d/%0d want=1/0/0", bus.pixValid, bus.pixCount, bus.lineCount);
      end
      tick();
      checks++;
      if (bus.pixCount !== 8'd1) begin errors++; $display("FAIL en_restart_next got=%0d want=1", bus.pixCount); end
   endtask

   task automatic test_reset_mid_line;
      bus.enable = 1'b0;
      tick();
      bus.enable = 1'b1;
      for (int k = 0; k < 30; k++) tick();
      checks++;
      if (bus.pixCount !== 8'd29) begin errors++; $display("FAIL rst_position got=%0d want=29", bus.pixCount); end
      #2 nReset = 1'b0;
      #1;
      checks++;
      if ({bus.HS, bus.VS, bus.pixValid, bus.pixCount, bus.lineCount, bus.field} !== 20'd0) begin
         errors++;
         $display("FAIL rst_async_clear got=%h want=0",
                  {bus.HS, bus.VS, bus.pixValid, bus.pixCount, bus.lineCount, bus.field});
      end
      #2 nReset = 1'b1;
      tick();
      checks++;
      if (bus.pixValid !== 1'b1 || bus.pixCount !== 8'd0 || bus.lineCount !== 8'd0) begin
         errors++;
         $display("FAIL rst_restart got=%b/%0d/%0d want=1/0/0", bus.pixValid, bus.pixCount, bus.lineCount);
      end
      tick();
      checks++;
      if (bus.pixCount !== 8'd1) begin errors++; $display("FAIL rst_restart_next got=%0d want=1", bus.pixCount); end
   endtask

   // HT=7, VT=5: HS only at h=5, VS only on line 3, active h<4 on lines 0..1.
   task automatic test_small;
      int h, v;
      logic exp_pv, exp_hs, exp_vs, exp_f;
      logic [7:0] exp_pc, exp_lc;
      int bad_pv, bad_hs, bad_vs, bad_cnt, bad_f, first_bad;
      logic [3:0] field_seq;
      bad_pv = 0; bad_hs = 0; bad_vs = 0; bad_cnt = 0; bad_f = 0; first_bad = -1;
      field_seq = 4'b0000;
      bus_s.enable = 1'b1;
      for (int k = 0; k <= 3 * S_FRAME; k++) begin
         tick();
         h      = k % 7;
         v      = (k / 7) % 5;
         exp_pv = (h < 4) && (v < 2);
         exp_hs = (h == 5);
         exp_vs = (v == 3);
         exp_pc = exp_pv ? 8'(h) : 8'd0;
         exp_lc = exp_pv ? 8'(v) : 8'd0;
         exp_f  = FIELD_EN ? 1'(((k + 1) / S_FRAME) % 2) : 1'b0;
         if (bus_s.pixValid !== exp_pv) begin bad_pv++; if (first_bad < 0) first_bad = k; end
         if (bus_s.HS !== exp_hs) begin bad_hs++; if (first_bad < 0) first_bad = k; end
         if (bus_s.VS !== exp_vs) begin bad_vs++; if (first_bad < 0) first_bad = k; end
         if (bus_s.pixCount !== exp_pc || bus_s.lineCount !== exp_lc) begin
            bad_cnt++;
            if (first_bad < 0) first_bad = k;
         end
         if (bus_s.field !== exp_f) begin bad_f++; if (first_bad < 0) first_bad = k; end
         if (k % S_FRAME == 0) field_seq[k / S_FRAME] = bus_s.field;
      end
      checks++;
      if (bad_pv !== 0) begin errors++; $display("FAIL small_pixValid wrong_cycles=%0d want=0 first_k=%0d", bad_pv, first_bad); end
      checks++;
      if (bad_hs !== 0) begin errors++; $display("FAIL small_HS wrong_cycles=%0d want=0 first_k=%0d", bad_hs, first_bad); end
      checks++;
      if (bad_vs !== 0) begin errors++; $display("FAIL small_VS wrong_cycles=%0d want=0 first_k=%0d", bad_vs, first_bad); end
      checks++;
      if (bad_cnt !== 0) begin errors++; $display("FAIL small_counts wrong_cycles=%0d want=0 first_k=%0d", bad_cnt, first_bad); end
      checks++;
      if (bad_f !== 0) begin errors++; $display("FAIL small_field wrong_cycles=%0d want=0 first_k=%0d", bad_f, first_bad); end
      checks++;
      if (field_seq !== (FIELD_EN ? 4'b1010 : 4'b0000)) begin
         errors++;
         $display("FAIL small_field_seq got=%b want=%b", field_seq, FIELD_EN ? 4'b1010 : 4'b0000);
      end
      bus_s.enable = 1'b0;
      tick();
      checks++;
      if (bus_s.field !== FIELD_EN || bus_s.pixValid !== 1'b0) begin
         errors++;
         $display("FAIL small_disable got=%b/%b want=%b/0", bus_s.field, bus_s.pixValid, FIELD_EN);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_line_frame();
      test_enable_low();
      test_reset_mid_line();
      test_small();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/el_timing_gen.md
EL_TIMING_GEN -- requirements
Module: el_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 80, meaning 4-pixel words per active line (320 px).
REQ-002 The block SHALL have parameter H_FP, default 4, meaning horizontal front-porch cycles.
REQ-003 The block SHALL have parameter H_SYNC, default 8, meaning HS pulse width in cycles.
REQ-004 The block SHALL have parameter H_BP, default 4, meaning horizontal back-porch cycles.
REQ-005 The block SHALL have parameter V_ACTIVE, default 240, meaning active lines per frame.
REQ-006 The block SHALL have parameters V_FP, V_SYNC and V_BP, each default 2, meaning vertical porch/sync widths in lines.
REQ-007 The block SHALL have port Vclk, input, 1 bit, meaning the single pixel-word clock; all logic on rising edge.
REQ-008 The block SHALL have port nReset, input, 1 bit, meaning asynchronous active-low reset.
REQ-009 The block SHALL have port enable, input, 1 bit, meaning run timing when high.
REQ-010 The block SHALL have port HS, output, 1 bit, meaning horizontal sync, active high.
REQ-011 The block SHALL have port VS, output, 1 bit, meaning vertical sync, active high.
REQ-012 The block SHALL have port pixValid, output, 1 bit, meaning current cycle is an active pixel word.
REQ-013 The block SHALL have port pixCount, output, 8 bits, meaning word index within active line.
REQ-014 The block SHALL have port lineCount, output, 8 bits, meaning active line index.
REQ-015 The block SHALL have port field, output, 1 bit, meaning odd/even frame indicator.

Function
REQ-016 The block SHALL keep an internal horizontal counter h (0..HT-1, HT=H_ACTIVE+H_FP+H_SYNC+H_BP, 96 default) incrementing by one per enabled cycle and wrapping to 0.
REQ-017 The block SHALL keep an internal vertical counter v (0..VT-1, VT=V_ACTIVE+V_FP+V_SYNC+V_BP, 246 default) incrementing only on the cycle h wraps, wrapping to 0 when at VT-1.
REQ-018 The block SHALL register all outputs, each reflecting the (h,v) of the same cycle (one-cycle latency from counter update, no combinational output paths).
REQ-019 The block SHALL assert pixValid when h<H_ACTIVE and v<V_ACTIVE, else 0.
REQ-020 The block SHALL drive pixCount=h and lineCount=v[7:0] while pixValid=1, and hold both at 0 otherwise.
REQ-021 The block SHALL assert HS for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] on every line, including vertical blanking lines.
REQ-022 The block SHALL assert VS for whole lines v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], rising and falling at h=0.
REQ-023 The block SHALL, when enable=0, synchronously force h=0, v=0 and HS, VS, pixValid, pixCount, lineCount to 0; field holds its value.
REQ-024 The block SHALL, on the first enabled cycle after enable rises, present h=0,v=0 (pixValid=1, pixCount=0, lineCount=0) on the next output update.
REQ-025 The block SHALL treat simultaneous h wrap and v wrap as a frame boundary: both counters return to 0 in the same cycle.
REQ-026 The block SHALL size internal counters to hold HT-1 and VT-1 without overflow for any parameter set with H_ACTIVE<=256 and V_ACTIVE<=256.

Reset
REQ-027 The block SHALL, while nReset=0, asynchronously clear h, v, HS, VS, pixValid, pixCount, lineCount and field to 0.
REQ-028 The block SHALL, after nReset deassertion mid-frame, restart from h=0,v=0 on the first enabled edge; no partial-frame state survives.

Configuration
REQ-029 The block SHALL, with macro EL_TIMING_FIELD_EN defined, toggle field on the cycle v wraps from VT-1 to 0.
REQ-030 The block SHALL, without EL_TIMING_FIELD_EN, tie field to constant 0 and instantiate no field register.

Verification
REQ-031 The bench SHALL cover reset then enable=1 with defaults -> pixValid high for cycles 0..79, HS high cycles 84..91, line period exactly 96 cycles.
REQ-032 The bench SHALL cover a full frame -> 240 lines with pixValid, VS high for lines 242..243 (192 cycles), frame period 23616 cycles.
REQ-033 The bench SHALL cover enable low at h=50,v=100 for 3 cycles -> all outputs 0 next cycle, restart at pixCount=0, lineCount=0.
REQ-034 The bench SHALL cover nReset pulse mid-line (h=30) -> outputs 0 immediately, no clock needed; restart at h=0.
REQ-035 The bench SHALL cover EL_TIMING_FIELD_EN defined, 3 frames -> field sequence 0,1,0,1 at each frame start; undefined -> field stays 0.
REQ-036 The bench SHALL cover override H_ACTIVE=4, H_FP=H_SYNC=H_BP=1, V_ACTIVE=2, all V_*=1 -> HT=7, VT=5, HS at h=5, VS on line 3.
